// File: rtl/eco_medidor.sv
// Ultrasonic ranging controller: fires a trigger pulse, times the synchronised echo
// high phase and converts it to whole centimetres with a prescaled counter.
module eco_medidor #(
   parameter int TRIG_CYCLES    = 500,
   parameter int CYC_PER_CM     = 2900,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int DIST_W         = 9,
   parameter int CNT_W          = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              echo,
   output logic              trig,
   output logic              busy,
   output logic              done,
   output logic              valid,
   output logic              timeout,
   output logic [DIST_W-1:0] distance
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TRIG      = 3'd1;
   localparam logic [2:0] ST_WAIT_RISE = 3'd2;
   localparam logic [2:0] ST_MEASURE   = 3'd3;
   localparam logic [2:0] ST_FINISH    = 3'd4;

   localparam logic [CNT_W-1:0]  TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PRESC_LAST = CNT_W'(CYC_PER_CM - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [DIST_W-1:0] CM_ONE     = DIST_W'(1);
   localparam logic [DIST_W-1:0] CM_MAX     = {DIST_W{1'b1}};

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic [DIST_W-1:0] cm_q, cm_d;
   logic [DIST_W-1:0] distance_q, distance_d;
   logic              trig_q, trig_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic              echo_m_q, echo_s_q, echo_p_q;

   logic              echo_rise, echo_fall;
   logic [CNT_W-1:0]  presc_nxt;
   logic [DIST_W-1:0] cm_nxt;

   assign echo_rise = echo_s_q & ~echo_p_q;
   assign echo_fall = ~echo_s_q & echo_p_q;

   // The fall cycle still counts as a high cycle, so the result is floor(high/CYC_PER_CM).
   always_comb begin
      presc_nxt = presc_q + CNT_ONE;
      cm_nxt    = cm_q;
      if (presc_q == PRESC_LAST) begin
         presc_nxt = '0;
         cm_nxt    = (cm_q == CM_MAX) ? cm_q : cm_q + CM_ONE;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      presc_d    = presc_q;
      cm_d       = cm_q;
      distance_d = distance_q;
      trig_d     = trig_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      valid_d    = valid_q;
      timeout_d  = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_TRIG;
               busy_d  = 1'b1;
               trig_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_TRIG: begin
            if (cnt_q == TRIG_LAST) begin
               state_d = ST_WAIT_RISE;
               trig_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT_RISE: begin
            if (echo_rise) begin
               state_d = ST_MEASURE;
               presc_d = '0;
               cm_d    = '0;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               state_d   = ST_FINISH;
               done_d    = 1'b1;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_MEASURE: begin
            presc_d = presc_nxt;
            cm_d    = cm_nxt;
            if (echo_fall) begin
               state_d    = ST_FINISH;
               done_d     = 1'b1;
               valid_d    = 1'b1;
               timeout_d  = 1'b0;
               distance_d = cm_nxt;
            end else if (cnt_q == TMO_LAST) begin
               state_d   = ST_FINISH;
               done_d    = 1'b1;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         presc_q    <= '0;
         cm_q       <= '0;
         distance_q <= '0;
         trig_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         echo_m_q   <= 1'b0;
         echo_s_q   <= 1'b0;
         echo_p_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         presc_q    <= presc_d;
         cm_q       <= cm_d;
         distance_q <= distance_d;
         trig_q     <= trig_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         echo_m_q   <= echo;
         echo_s_q   <= echo_m_q;
         echo_p_q   <= echo_s_q;
      end
   end

   assign trig     = trig_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign valid    = valid_q;
   assign timeout  = timeout_q;
   assign distance = distance_q;

endmodule

// File: tb/tb_eco_medidor.sv
// Randomised bench for eco_medidor: two instances (short and long timeout) share the
// stimulus and are compared against a pulse-length based reference model.
module tb_eco_medidor;

   localparam int TRIG   = 5;
   localparam int CPC    = 10;
   localparam int TMO    = 200;
   localparam int TMO_S  = 1000;
   localparam int DW     = 6;
   localparam int DMAX   = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst, start, echo;
   logic trig, busy, done, valid, timeout;
   logic trig_s, busy_s, done_s, valid_s, timeout_s;
   logic [DW-1:0] distance, distance_s;

   eco_medidor #(.TRIG_CYCLES(TRIG), .CYC_PER_CM(CPC), .TIMEOUT_CYCLES(TMO),
                 .DIST_W(DW), .CNT_W(21)) u_dut (
      .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig), .busy(busy),
      .done(done), .valid(valid), .timeout(timeout), .distance(distance));

   eco_medidor #(.TRIG_CYCLES(TRIG), .CYC_PER_CM(CPC), .TIMEOUT_CYCLES(TMO_S),
                 .DIST_W(DW), .CNT_W(21)) u_sat (
      .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig_s), .busy(busy_s),
      .done(done_s), .valid(valid_s), .timeout(timeout_s), .distance(distance_s));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference results per instance: [0] short timeout, [1] long timeout.
   int m_dist[2];
   int m_valid[2];
   int m_to[2];
   int tmo_of[2] = '{TMO, TMO_S};

   function automatic void model(input int n, input bit partial);
      for (int i = 0; i < 2; i++) begin
         if (partial || n == 0 || n > tmo_of[i]) begin
            m_valid[i] = 0;
            m_to[i]    = 1;
         end else begin
            m_valid[i] = 1;
            m_to[i]    = 0;
            m_dist[i]  = (n / CPC > DMAX) ? DMAX : n / CPC;
         end
      end
   endfunction

   int   done_cnt0 = 0, done_cnt1 = 0, trig_rise = 0;
   logic prev_done0 = 1'b0, prev_done1 = 1'b0, prev_trig = 1'b0;

   always @(negedge clk) begin
      if (prev_done0) check("busy_after_done", busy, 0);
      if (prev_done1) check("busy_after_done_s", busy_s, 0);
      if (done) done_cnt0++;
      if (done_s) done_cnt1++;
      if (trig && !prev_trig) trig_rise++;
      prev_done0 = done;
      prev_done1 = done_s;
      prev_trig  = trig;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_dist"},     distance,   m_dist[0]);
      check({tag, "_valid"},    valid,      m_valid[0]);
      check({tag, "_timeout"},  timeout,    m_to[0]);
      check({tag, "_dist_s"},   distance_s, m_dist[1]);
      check({tag, "_valid_s"},  valid_s,    m_valid[1]);
      check({tag, "_timeout_s"}, timeout_s, m_to[1]);
   endtask

   // One measurement: start, trigger length check, echo pulse of n cycles after dly.
   task automatic run(input int dly, input int n, input bit partial, input bit extra,
                      input string tag);
      int d0, d1, tr0, tcyc, guard;
      d0 = done_cnt0; d1 = done_cnt1; tr0 = trig_rise; tcyc = 0; guard = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (partial) echo = 1'b1;
      while (trig && tcyc < 50) begin
         start = (extra && tcyc == 1);
         tcyc++;
         tick();
      end
      start = 1'b0;
      check({tag, "_trig_len"}, tcyc, TRIG);
      if (partial) begin
         repeat (n) tick();
         echo = 1'b0;
      end else begin
         repeat (dly) tick();
         if (n > 0) begin
            echo = 1'b1;
            for (int i = 0; i < n; i++) begin
               start = (extra && i == n / 2);
               tick();
            end
            start = 1'b0;
            echo  = 1'b0;
         end
      end
      while ((busy || busy_s) && guard < 5000) begin
         guard++;
         tick();
      end
      check({tag, "_finished"}, guard < 5000, 1);
      tick();
      tick();
      model(n, partial);
      check_outputs(tag);
      check({tag, "_done_cnt"},   done_cnt0 - d0, 1);
      check({tag, "_done_cnt_s"}, done_cnt1 - d1, 1);
      check({tag, "_trig_rises"}, trig_rise - tr0, 1);
   endtask

   initial begin
      int d0, d1, n, dly;
      rst = 1'b1; start = 1'b0; echo = 1'b0;
      m_dist = '{0, 0}; m_valid = '{0, 0}; m_to = '{0, 0};
      repeat (3) tick();
      check("rst_trig", trig, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check_outputs("rst");
      rst = 1'b0;
      tick();

      run(20, 123, 1'b0, 1'b0, "basic");
      run(10, 0, 1'b0, 1'b0, "no_echo");
      run(10, 1100, 1'b0, 1'b0, "stuck");
      run(15, 57, 1'b0, 1'b0, "after_stuck");
      run(5, 900, 1'b0, 1'b0, "sat");
      run(8, 200, 1'b0, 1'b0, "fall_at_tmo");
      run(8, 201, 1'b0, 1'b0, "past_tmo");
      run(0, 50, 1'b1, 1'b0, "partial");
      run(12, 88, 1'b0, 1'b1, "extra_start");

      // Reset in the middle of a measurement.
      d0 = done_cnt0; d1 = done_cnt1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (TRIG + 5) tick();
      echo = 1'b1;
      repeat (40) tick();
      #2 rst = 1'b1;
      #1;
      m_dist = '{0, 0}; m_valid = '{0, 0}; m_to = '{0, 0};
      check("midrst_trig", trig, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_busy_s", busy_s, 0);
      check_outputs("midrst");
      tick();
      echo = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("midrst_no_done", done_cnt0 - d0, 0);
      check("midrst_no_done_s", done_cnt1 - d1, 0);

      run(7, 77, 1'b0, 1'b0, "post_reset");

      for (int k = 0; k < 10; k++) begin
         dly = $urandom_range(60, 1);
         n   = $urandom_range(260, 0);
         run(dly, n, 1'b0, 1'b0, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eco_medidor.md
Name: eco_medidor

Overview:
- Ultrasonic ranging controller for the HC-SR04 front sensor. It sits directly downstream of the 1 s periodic timer, whose `done` pulse drives `start`.
- On each start it emits a trigger pulse, measures the echo high time, and converts it to whole centimetres with a prescaled counter (no divider).
- Publishes a held distance plus done/valid/timeout flags to the motion FSM.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
CYC_PER_CM, 2900, clk cycles of echo high per 1 cm (58 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max cycles for each wait phase (30 ms at 50 MHz)
DIST_W, 9, distance width in cm; saturates at 2^DIST_W-1
CNT_W, 21, width of internal cycle counters; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  measurement request, sampled high for one cycle; ignored while busy
echo  in  1  raw sensor echo, asynchronous to clk
trig  out  1  sensor trigger pulse
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of every measurement, success or timeout
valid  out  1  high when distance holds a good measurement; updated with done
timeout  out  1  high when the last measurement timed out; updated with done
distance  out  DIST_W  last good distance in cm; held between measurements

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; trig, busy, done, valid, timeout = 0; distance = 0; all counters and sync flops = 0.
- Echo input:
  - Two-flop synchroniser, then a registered copy for edge detection.
  - Rise = sync high and previous low; fall = sync low and previous high.
  - Echo sees 2 cycles of input latency; the cm result absorbs it without compensation.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, FINISH.
- IDLE:
  - When start=1: go to TRIG, busy=1, trig=1, cycle counter=0.
  - start is ignored in every other state; it is not queued.
- TRIG:
  - trig held high exactly TRIG_CYCLES cycles.
  - Counter reaches TRIG_CYCLES-1: trig=0, counter=0, go to WAIT_RISE.
- WAIT_RISE:
  - On rise: go to MEASURE, prescaler=0, cm count=0, timeout counter=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no rise: go to FINISH with timeout result.
- MEASURE:
  - Each cycle the prescaler increments. At CYC_PER_CM-1 it wraps to 0 and cm count increments.
  - cm count saturates at 2^DIST_W-1 and does not wrap.
  - On fall: go to FINISH with success result. distance = cm count as it stands that cycle, i.e. floor(high cycles / CYC_PER_CM).
  - If echo stays high for TIMEOUT_CYCLES: timeout result.
  - Fall and timeout in the same cycle: fall wins (success).
- FINISH (one cycle):
  - done=1.
  - Success: valid=1, timeout=0, distance updated.
  - Timeout: valid=0, timeout=1, distance keeps its previous value.
  - Next cycle: done=0, busy=0, state=IDLE.
  - A start in this cycle is ignored; a start in the following IDLE cycle is accepted.
- Echo already high when entering WAIT_RISE: no rise is detected. The block waits for a genuine rise or a timeout and does not measure a partial pulse.
- Reset mid-operation: all outputs drop immediately, trig included. No done pulse is emitted.
- Illegal or unused state encodings return to IDLE.
- valid and timeout persist until the next FINISH.

Test Plan:
Sim parameters: TRIG_CYCLES=5, CYC_PER_CM=10, TIMEOUT_CYCLES=200, DIST_W=6.
1. Basic: start pulse, echo high 123 cycles, 20 cycles after trig falls -> trig high exactly 5 cycles; one done pulse; valid=1, timeout=0, distance=12; busy low the cycle after done.
2. No echo: start, echo held low -> done about 205 cycles after start; timeout=1, valid=0; distance unchanged from scenario 1 (12).
3. Stuck echo: echo rises and stays high -> timeout=1 after 200 MEASURE cycles; trig never re-asserts; a subsequent good 57-cycle echo gives distance=5, valid=1, timeout=0.
4. Saturation: run with TIMEOUT_CYCLES=1000 and echo high 900 cycles -> distance=63 (saturated), valid=1.
5. Start while busy and reset mid-op: extra start pulses during TRIG/MEASURE -> exactly one done. rst asserted mid-MEASURE -> trig/busy/done/valid/timeout/distance all 0 in the same cycle, with no done pulse; the next start measures normally.
